// File: rtl/sps_match_controller_if.sv
// Bus between the match controller, the player input logic and the stone/paper/scissors core.
// master is the controller's view; slave is the view of the logic around it.
interface sps_match_controller_if;
  logic       match_start;
  logic       mode;
  logic       p1_valid;
  logic [1:0] p1_move_in;
  logic       p2_valid;
  logic [1:0] p2_move_in;
  logic [1:0] winner;
  logic       core_start;
  logic [1:0] core_p1_move;
  logic [1:0] core_p2_move;
  logic       core_mode;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic [3:0] round_cnt;
  logic       match_done;
  logic [1:0] match_winner;
  logic       busy;

  modport master (
    input  match_start, mode, p1_valid, p1_move_in, p2_valid, p2_move_in, winner,
    output core_start, core_p1_move, core_p2_move, core_mode,
           score_p1, score_p2, round_cnt, match_done, match_winner, busy
  );

  modport slave (
    output match_start, mode, p1_valid, p1_move_in, p2_valid, p2_move_in, winner,
    input  core_start, core_p1_move, core_p2_move, core_mode,
           score_p1, score_p2, round_cnt, match_done, match_winner, busy
  );
endinterface

// File: rtl/sps_match_controller.sv
// Best-of-N match sequencer for the stone/paper/scissors core, with an LFSR computer opponent.
// state   | meaning
// IDLE    | after reset, waiting for match_start
// COLLECT | capturing both players' moves
// FIRE    | one-cycle start pulse to the core
// WAIT    | RESULT_WAIT cycles for the core result; winner sampled on the exit edge
// SCORE   | scores updated, decide next round or end of match
// DONE    | match over, results held until match_start
module sps_match_controller #(
  parameter int unsigned WIN_TARGET  = 3,
  parameter int unsigned RESULT_WAIT = 2,
  parameter int unsigned MAX_ROUNDS  = 15,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input logic                    i_clk,
  input logic                    i_reset,
  sps_match_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_FIRE, S_WAIT, S_SCORE, S_DONE
  } state_t;

  localparam logic [3:0] WinTgt   = 4'(WIN_TARGET);
  localparam logic [3:0] MaxRnd   = 4'(MAX_ROUNDS);
  localparam logic [3:0] WaitLoad = 4'(RESULT_WAIT - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_lfsr;
  logic       r_p1_got;
  logic       r_p2_got;
  logic [1:0] r_p1_move;
  logic [1:0] r_p2_move;
  logic       r_mode;
  logic [3:0] r_score_p1;
  logic [3:0] r_score_p2;
  logic [3:0] r_round_cnt;
  logic [3:0] r_wait_cnt;

  logic       w_lfsr_fb;
  logic [1:0] w_cpu_move;
  logic       w_start_ok;
  logic       w_p1_cap;
  logic       w_p2_cap;
  logic       w_wait_done;
  logic       w_match_over;
  logic       w_core_start;
  logic       w_busy;
  logic       w_match_done;
  logic [1:0] w_match_winner;

  assign w_lfsr_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_cpu_move   = (r_lfsr[1:0] == 2'b11) ? 2'b00 : r_lfsr[1:0];
  assign w_start_ok   = bus.match_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_p1_cap     = (r_state == S_COLLECT) && !r_p1_got && bus.p1_valid;
  // In computer mode P2 is always "ready", so it is taken in the first COLLECT cycle.
  assign w_p2_cap     = (r_state == S_COLLECT) && !r_p2_got && (r_mode || bus.p2_valid);
  assign w_wait_done  = (r_wait_cnt == 4'd0);
  assign w_match_over = (r_score_p1 == WinTgt) || (r_score_p2 == WinTgt) ||
                        (r_round_cnt == MaxRnd);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_start_ok) w_state_nxt = S_COLLECT;
      S_COLLECT:      if ((r_p1_got || w_p1_cap) && (r_p2_got || w_p2_cap)) w_state_nxt = S_FIRE;
      S_FIRE:         w_state_nxt = S_WAIT;
      S_WAIT:         if (w_wait_done) w_state_nxt = S_SCORE;
      S_SCORE:        w_state_nxt = w_match_over ? S_DONE : S_COLLECT;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_core_start   = (r_state == S_FIRE);
    w_busy         = (r_state != S_IDLE) && (r_state != S_DONE);
    w_match_done   = (r_state == S_DONE);
    w_match_winner = 2'b00;
    if (r_state == S_DONE) begin
      if (r_score_p1 > r_score_p2)      w_match_winner = 2'b01;
      else if (r_score_p2 > r_score_p1) w_match_winner = 2'b10;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_lfsr      <= LFSR_SEED;
      r_p1_got    <= 1'b0;
      r_p2_got    <= 1'b0;
      r_p1_move   <= 2'b00;
      r_p2_move   <= 2'b00;
      r_mode      <= 1'b0;
      r_score_p1  <= 4'd0;
      r_score_p2  <= 4'd0;
      r_round_cnt <= 4'd0;
      r_wait_cnt  <= 4'd0;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
      if (w_start_ok) begin
        r_mode      <= bus.mode;
        r_score_p1  <= 4'd0;
        r_score_p2  <= 4'd0;
        r_round_cnt <= 4'd0;
        r_p1_got    <= 1'b0;
        r_p2_got    <= 1'b0;
      end
      if (w_p1_cap) begin
        r_p1_got  <= 1'b1;
        r_p1_move <= bus.p1_move_in;
      end
      if (w_p2_cap) begin
        r_p2_got  <= 1'b1;
        r_p2_move <= r_mode ? w_cpu_move : bus.p2_move_in;
      end
      if (r_state == S_FIRE)                      r_wait_cnt <= WaitLoad;
      else if (r_state == S_WAIT && !w_wait_done) r_wait_cnt <= r_wait_cnt - 4'd1;
      // Score lands on the SCORE entry edge so SCORE can decide on the updated totals.
      if (r_state == S_WAIT && w_wait_done) begin
        r_round_cnt <= r_round_cnt + 4'd1;
        if (bus.winner == 2'b01) r_score_p1 <= r_score_p1 + 4'd1;
        if (bus.winner == 2'b10) r_score_p2 <= r_score_p2 + 4'd1;
      end
      if (r_state == S_SCORE) begin
        r_p1_got <= 1'b0;
        r_p2_got <= 1'b0;
      end
    end
  end

  assign bus.core_start   = w_core_start;
  assign bus.core_p1_move = r_p1_move;
  assign bus.core_p2_move = r_p2_move;
  assign bus.core_mode    = r_mode;
  assign bus.score_p1     = r_score_p1;
  assign bus.score_p2     = r_score_p2;
  assign bus.round_cnt    = r_round_cnt;
  assign bus.match_done   = w_match_done;
  assign bus.match_winner = w_match_winner;
  assign bus.busy         = w_busy;

endmodule

// File: tb/tb_sps_match_controller.sv
// Directed bench for sps_match_controller: dut_a (WIN_TARGET=2, MAX_ROUNDS=4), dut_b (WIN_TARGET=3).
// Both DUTs see the same player/core inputs; each scenario watches one of them.
module tb_sps_match_controller;
  logic       clk;
  logic       rst_n;
  logic       match_start;
  logic       mode;
  logic       p1_valid;
  logic [1:0] p1_move;
  logic       p2_valid;
  logic [1:0] p2_move;
  logic [1:0] winner;
  logic [7:0] m_lfsr;
  int         n_checks;
  int         n_errors;

  sps_match_controller_if bus_a ();
  sps_match_controller_if bus_b ();

  assign bus_a.match_start = match_start;
  assign bus_a.mode        = mode;
  assign bus_a.p1_valid    = p1_valid;
  assign bus_a.p1_move_in  = p1_move;
  assign bus_a.p2_valid    = p2_valid;
  assign bus_a.p2_move_in  = p2_move;
  assign bus_a.winner      = winner;
  assign bus_b.match_start = match_start;
  assign bus_b.mode        = mode;
  assign bus_b.p1_valid    = p1_valid;
  assign bus_b.p1_move_in  = p1_move;
  assign bus_b.p2_valid    = p2_valid;
  assign bus_b.p2_move_in  = p2_move;
  assign bus_b.winner      = winner;

  sps_match_controller #(.WIN_TARGET(2), .RESULT_WAIT(2), .MAX_ROUNDS(4)) u_dut_a (
    .i_clk(clk), .i_reset(rst_n), .bus(bus_a));
  sps_match_controller #(.WIN_TARGET(3), .RESULT_WAIT(2), .MAX_ROUNDS(15)) u_dut_b (
    .i_clk(clk), .i_reset(rst_n), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference opponent LFSR: x^8+x^6+x^5+x^4+1, shifting toward the MSB.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 8'hA5;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] cpu_move(input logic [7:0] l);
    logic [1:0] m;
    m = l[1:0];
    return (m == 2'b11) ? 2'b00 : m;
  endfunction

  function automatic logic [21:0] outs_a();
    return {bus_a.core_start, bus_a.core_p1_move, bus_a.core_p2_move, bus_a.core_mode,
            bus_a.score_p1, bus_a.score_p2, bus_a.round_cnt, bus_a.match_done,
            bus_a.match_winner, bus_a.busy};
  endfunction

  function automatic logic [4:0] fire_view(input bit sel);
    return sel ? {bus_b.core_start, bus_b.core_p1_move, bus_b.core_p2_move}
               : {bus_a.core_start, bus_a.core_p1_move, bus_a.core_p2_move};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; match_start = 1'b0; mode = 1'b0;
    p1_valid = 1'b0; p2_valid = 1'b0; p1_move = 2'b00; p2_move = 2'b00; winner = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_match(input logic m);
    match_start = 1'b1; mode = m;
    @(negedge clk);
    match_start = 1'b0;
  endtask

  // Called at a COLLECT negedge; returns at the negedge of the next COLLECT (or DONE) cycle.
  task automatic play_round(input bit sel, input int idle, input logic [1:0] m1,
                            input logic [1:0] m2_drv, input logic [1:0] m2_exp,
                            input logic [1:0] w, input string tag);
    logic [4:0] v;
    winner = w;
    repeat (idle) @(negedge clk);
    p1_valid = 1'b1; p1_move = m1; p2_valid = 1'b1; p2_move = m2_drv;
    @(negedge clk);
    p1_valid = 1'b0; p2_valid = 1'b0;
    v = fire_view(sel);
    chk({tag, ".start"}, 32'(v[4]), 32'd1);
    chk({tag, ".moves"}, 32'(v[3:0]), 32'({m1, m2_exp}));
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n_pulse;
    int         pulse_cyc;
    logic [1:0] e_mv;
    n_checks = 0; n_errors = 0;

    do_reset();
    chk("reset.outs_a", 32'(outs_a()), 32'd0);

    // T1: P1 wins twice on dut_a, plus a match_start while busy
    start_match(1'b0);
    play_round(1'b0, 0, 2'b00, 2'b10, 2'b10, 2'b01, "t1r1");
    chk("t1.r1_score_p1", 32'(bus_a.score_p1), 32'd1);
    chk("t1.r1_busy", 32'({bus_a.busy, bus_a.match_done}), 32'b10);
    match_start = 1'b1;
    @(negedge clk);
    match_start = 1'b0;
    chk("t1.start_ignored", 32'({bus_a.score_p1, bus_a.round_cnt}), 32'h11);
    play_round(1'b0, 0, 2'b00, 2'b10, 2'b10, 2'b01, "t1r2");
    chk("t1.score", 32'({bus_a.score_p1, bus_a.score_p2}), 32'h20);
    chk("t1.round_cnt", 32'(bus_a.round_cnt), 32'd2);
    chk("t1.done", 32'({bus_a.match_done, bus_a.match_winner, bus_a.busy}), 32'b1010);
    p1_valid = 1'b1; p2_valid = 1'b1;
    repeat (3) @(negedge clk);
    p1_valid = 1'b0; p2_valid = 1'b0;
    chk("t1.done_hold", 32'({bus_a.match_done, bus_a.round_cnt, bus_a.core_start}), 32'b1_0010_0);

    // T4: new match from DONE, MAX_ROUNDS=4 with all ties
    start_match(1'b0);
    chk("t4.cleared", 32'({bus_a.score_p1, bus_a.round_cnt, bus_a.match_done, bus_a.busy}),
        32'b0000_0000_0_1);
    for (int r = 0; r < 3; r++) play_round(1'b0, 0, 2'b01, 2'b01, 2'b01, 2'b00, "t4r");
    chk("t4.r3_not_done", 32'({bus_a.match_done, bus_a.round_cnt}), 32'h03);
    play_round(1'b0, 0, 2'b01, 2'b01, 2'b01, 2'b00, "t4r4");
    chk("t4.done", 32'({bus_a.match_done, bus_a.round_cnt, bus_a.match_winner}), 32'b1_0100_00);

    // T4b: round cap reached with P1 ahead 1-0
    start_match(1'b0);
    play_round(1'b0, 0, 2'b10, 2'b01, 2'b01, 2'b01, "t4b1");
    for (int r = 0; r < 3; r++) play_round(1'b0, 0, 2'b00, 2'b00, 2'b00, 2'b00, "t4b");
    chk("t4b.done", 32'({bus_a.match_done, bus_a.round_cnt, bus_a.match_winner}), 32'b1_0100_01);
    chk("t4b.score", 32'({bus_a.score_p1, bus_a.score_p2}), 32'h10);

    // T2: strobes at COLLECT cycles 3 (P1), 5 (P1 repeat) and 7 (P2)
    do_reset();
    start_match(1'b0);
    n_pulse = 0; pulse_cyc = 0;
    for (int c = 1; c <= 12; c++) begin
      if (bus_a.core_start) begin
        n_pulse++;
        pulse_cyc = c;
      end
      if (c >= 8 && c <= 10)
        chk($sformatf("t2.moves_c%0d", c), 32'({bus_a.core_p1_move, bus_a.core_p2_move}), 32'b0110);
      p1_valid = (c == 3) || (c == 5);
      p1_move  = (c == 3) ? 2'b01 : 2'b10;
      p2_valid = (c == 7);
      p2_move  = 2'b10;
      winner   = 2'b10;
      @(negedge clk);
    end
    p1_valid = 1'b0; p2_valid = 1'b0;
    chk("t2.pulses", 32'(n_pulse), 32'd1);
    chk("t2.pulse_cycle", 32'(pulse_cyc), 32'd8);
    chk("t2.score", 32'({bus_a.score_p2, bus_a.round_cnt}), 32'h11);

    // T5: computer opponent, P2 strobes driven with 11 must be ignored
    do_reset();
    start_match(1'b1);
    chk("t5.core_mode", 32'(bus_a.core_mode), 32'd1);
    e_mv = cpu_move(m_lfsr);
    play_round(1'b0, 0, 2'b00, 2'b11, e_mv, 2'b00, "t5r1");
    e_mv = cpu_move(m_lfsr);
    play_round(1'b0, 3, 2'b01, 2'b11, e_mv, 2'b00, "t5r2");
    chk("t5.p2_not_11", 32'(bus_a.core_p2_move == 2'b11), 32'd0);
    chk("t5.rounds", 32'(bus_a.round_cnt), 32'd2);

    // T3: tie, invalid, then three P2 wins on dut_b
    do_reset();
    start_match(1'b0);
    play_round(1'b1, 0, 2'b00, 2'b00, 2'b00, 2'b00, "t3r1");
    play_round(1'b1, 0, 2'b11, 2'b01, 2'b01, 2'b11, "t3r2");
    chk("t3.r2", 32'({bus_b.round_cnt, bus_b.score_p1, bus_b.score_p2, bus_b.busy}), 32'b0010_0000_0000_1);
    play_round(1'b1, 0, 2'b00, 2'b01, 2'b01, 2'b10, "t3r3");
    play_round(1'b1, 0, 2'b10, 2'b00, 2'b00, 2'b10, "t3r4");
    chk("t3.r4", 32'({bus_b.match_done, bus_b.score_p2}), 32'h02);
    play_round(1'b1, 0, 2'b01, 2'b10, 2'b10, 2'b10, "t3r5");
    chk("t3.round_cnt", 32'(bus_b.round_cnt), 32'd5);
    chk("t3.score", 32'({bus_b.score_p1, bus_b.score_p2}), 32'h03);
    chk("t3.done", 32'({bus_b.match_done, bus_b.match_winner}), 32'b110);

    // T6: reset during WAIT of round 2
    do_reset();
    start_match(1'b0);
    play_round(1'b0, 0, 2'b00, 2'b10, 2'b10, 2'b01, "t6r1");
    winner = 2'b01;
    p1_valid = 1'b1; p1_move = 2'b01; p2_valid = 1'b1; p2_move = 2'b00;
    @(negedge clk);
    p1_valid = 1'b0; p2_valid = 1'b0;
    @(negedge clk);
    chk("t6.pre_reset", 32'({bus_a.score_p1, bus_a.busy}), 32'b0001_1);
    #2 rst_n = 1'b0;
    #1 chk("t6.async_zero", 32'(outs_a()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_match(1'b0);
    chk("t6.restart", 32'({bus_a.round_cnt, bus_a.score_p1, bus_a.busy}), 32'b0000_0000_1);
    play_round(1'b0, 0, 2'b10, 2'b00, 2'b00, 2'b10, "t6r2");
    chk("t6.after", 32'({bus_a.round_cnt, bus_a.score_p1, bus_a.score_p2}), 32'h101);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
